// File: rtl/axi_interface_master_pkg.sv
// Shared widths, AXI encodings and response helper for the AXI4 initiator.
package axi_interface_master_pkg;

  localparam int ID_BITS    = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int LEN_BITS   = 8;
  localparam int SIZE_BITS  = 3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [SIZE_BITS-1:0] AXI_SIZE = SIZE_BITS'($clog2(DATA_WIDTH / 8));

  // Response codes are ordered by severity, so the worst one is the numeric max.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_interface_master.sv
// AXI4 initiator: one outstanding INCR burst, native command/data streams in,
// AW/W/B/AR/R out, with a per-wait-state timeout that aborts a hung slave.
module axi_interface_master
  import axi_interface_master_pkg::*;
#(
  parameter logic [ID_BITS-1:0] AXI_ID  = 4'd0,
  parameter int unsigned        TIMEOUT = 32'd1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_BITS-1:0]     cmd_len,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic [ID_BITS-1:0]      awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [LEN_BITS-1:0]     awlen,
  output logic [SIZE_BITS-1:0]    awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_BITS-1:0]      bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ID_BITS-1:0]      arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [LEN_BITS-1:0]     arlen,
  output logic [SIZE_BITS-1:0]    arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_BITS-1:0]      rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RADDR = 3'd4,
    RDATA = 3'd5
  } axi_mst_state_e;

  axi_mst_state_e          state_r, state_next_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [LEN_BITS-1:0]     len_r;
  logic [LEN_BITS-1:0]     beat_cnt_r;
  logic [1:0]              resp_acc_r;
  logic [31:0]             timer_r;
  logic                    rd_valid_r, rd_last_r, done_r;
  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic [1:0]              done_resp_r;
  logic                    waiting_s, timeout_s, last_cnt_s, rd_last_beat_s, rd_err_s;
  logic [1:0]              acc_next_s;

  assign awid      = AXI_ID;
  assign arid      = AXI_ID;
  assign awsize    = AXI_SIZE;
  assign arsize    = AXI_SIZE;
  assign awburst   = BURST_INCR;
  assign arburst   = BURST_INCR;
  assign awaddr    = addr_r;
  assign araddr    = addr_r;
  assign awlen     = len_r;
  assign arlen     = len_r;
  assign wdata     = wd_data;
  assign wstrb     = wd_strb;
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_r;
  assign rd_last   = rd_last_r;
  assign done      = done_r;
  assign done_resp = done_resp_r;

  assign last_cnt_s     = (beat_cnt_r == len_r);
  // A beat is final on rlast, or once the counter reaches len even without rlast.
  assign rd_last_beat_s = rlast || last_cnt_s;
  assign rd_err_s       = (rid != AXI_ID) || (rlast != last_cnt_s);
  assign acc_next_s     = resp_max(resp_max(resp_acc_r, rresp),
                                   rd_err_s ? RESP_SLVERR : RESP_OKAY);
  assign timeout_s      = (TIMEOUT != 32'd0) && waiting_s && (timer_r == TIMEOUT - 32'd1);

  // Which cycles count as stalled on the slave or native side.
  always_comb begin
    waiting_s = 1'b0;
    case (state_r)
      WADDR:   waiting_s = !awready;
      WDATA:   waiting_s = !(wd_valid && wready);
      WRESP:   waiting_s = !bvalid;
      RADDR:   waiting_s = !arready;
      RDATA:   waiting_s = !rvalid;
      default: waiting_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= IDLE;
    else         state_r <= state_next_s;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next_s = state_r;
    cmd_ready    = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    wlast        = 1'b0;
    wd_ready     = 1'b0;
    bready       = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (state_r)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next_s = cmd_we ? WADDR : RADDR;
        else           state_next_s = IDLE;
      end
      WADDR: begin
        awvalid = 1'b1;
        if (awready) state_next_s = WDATA;
        else         state_next_s = WADDR;
      end
      WDATA: begin
        wvalid   = wd_valid;
        wd_ready = wready;
        wlast    = last_cnt_s;
        if (wd_valid && wready && last_cnt_s) state_next_s = WRESP;
        else                                  state_next_s = WDATA;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) state_next_s = IDLE;
        else        state_next_s = WRESP;
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_next_s = RDATA;
        else         state_next_s = RADDR;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid && rd_last_beat_s) state_next_s = IDLE;
        else                          state_next_s = RDATA;
      end
      default: state_next_s = IDLE;
    endcase
    if (timeout_s) state_next_s = IDLE;
    else           state_next_s = state_next_s;
  end

  // Wait timer: any non-stalled cycle (handshake or state change) clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     timer_r <= 32'd0;
    else if (waiting_s && !timeout_s) timer_r <= timer_r + 32'd1;
    else                             timer_r <= 32'd0;
  end

  // Command latch, beat counting, read capture and completion reporting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_r      <= '0;
      len_r       <= '0;
      beat_cnt_r  <= '0;
      resp_acc_r  <= RESP_OKAY;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= '0;
      rd_last_r   <= 1'b0;
      done_r      <= 1'b0;
      done_resp_r <= RESP_OKAY;
    end else begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      done_r     <= 1'b0;
      if (timeout_s) begin
        done_r      <= 1'b1;
        done_resp_r <= RESP_DECERR;
      end else begin
        case (state_r)
          IDLE: if (cmd_valid) begin
            addr_r <= cmd_addr;
            len_r  <= cmd_len;
          end
          WADDR: if (awready) beat_cnt_r <= '0;
          WDATA: if (wd_valid && wready && !last_cnt_s) beat_cnt_r <= beat_cnt_r + LEN_BITS'(1);
          WRESP: if (bvalid) begin
            done_r      <= 1'b1;
            done_resp_r <= (bid != AXI_ID) ? RESP_SLVERR : bresp;
          end
          RADDR: if (arready) begin
            beat_cnt_r <= '0;
            resp_acc_r <= RESP_OKAY;
          end
          RDATA: if (rvalid) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= rdata;
            rd_last_r  <= rd_last_beat_s;
            resp_acc_r <= acc_next_s;
            beat_cnt_r <= beat_cnt_r + LEN_BITS'(1);
            if (rd_last_beat_s) begin
              done_r      <= 1'b1;
              done_resp_r <= acc_next_s;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_interface_master.sv
// Scoreboard bench for axi_interface_master: a bus agent models the native
// write source and an AXI slave, and compares every handshake against queues.
module tb_axi_interface_master;
  import axi_interface_master_pkg::*;

  typedef struct { logic [ADDR_WIDTH-1:0] addr; logic [LEN_BITS-1:0] len; } addr_t;
  typedef struct { logic [DATA_WIDTH-1:0] data; logic [3:0] strb; logic last; } wbeat_t;
  typedef struct { logic [DATA_WIDTH-1:0] data; logic [1:0] resp; logic last; } rbeat_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic cmd_valid, cmd_ready, cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_BITS-1:0] cmd_len;
  logic wd_valid, wd_ready;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [3:0] wd_strb;
  logic rd_valid, rd_last, done;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0] done_resp;
  logic [ID_BITS-1:0] awid, bid, arid, rid;
  logic [ADDR_WIDTH-1:0] awaddr, araddr;
  logic [LEN_BITS-1:0] awlen, arlen;
  logic [SIZE_BITS-1:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic [3:0] wstrb;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  addr_t  exp_aw_q[$], exp_ar_q[$];
  wbeat_t wr_src_q[$], exp_w_q[$];
  rbeat_t rd_plan_q[$], exp_rd_q[$];
  logic [1:0] exp_done_q[$];

  int aw_delay = 0, aw_wait = 0;
  bit w_alt = 1'b0, w_tog = 1'b0, w_block = 1'b0;
  bit b_en = 1'b1, b_pending = 1'b0, r_active = 1'b0;
  logic [1:0] b_resp_cfg = 2'd0;
  logic [ID_BITS-1:0] b_id_cfg = 4'd0;

  axi_interface_master #(.AXI_ID(4'd0), .TIMEOUT(32'd16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk_i = ~clk_i;

  task automatic bus_agent();
    wbeat_t wb;
    rbeat_t rb;
    logic [1:0] dr;
    forever begin
      @(negedge clk_i);
      if (rd_valid) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got beat %h, required none", rd_data);
        end else begin
          rb = exp_rd_q.pop_front();
          if (rd_data !== rb.data || rd_last !== rb.last || done !== rb.last) begin
            errors++;
            $display("FAIL rd_beat: got data %h last %b done %b, required data %h last %b done %b",
                     rd_data, rd_last, done, rb.data, rb.last, rb.last);
          end
        end
      end
      if (done) begin
        checks++;
        done_seen++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done resp %0d, required no done", done_resp);
        end else begin
          dr = exp_done_q.pop_front();
          if (done_resp !== dr) begin
            errors++;
            $display("FAIL done_resp: got %0d, required %0d", done_resp, dr);
          end
        end
      end
      if (wr_src_q.size() > 0) begin
        wd_valid = 1'b1; wd_data = wr_src_q[0].data; wd_strb = wr_src_q[0].strb;
      end else begin
        wd_valid = 1'b0;
      end
      awready = awvalid && (aw_wait >= aw_delay);
      wready  = w_block ? 1'b0 : (w_alt ? w_tog : 1'b1);
      bvalid  = b_pending && b_en; bresp = b_resp_cfg; bid = b_id_cfg;
      arready = arvalid;
      if (r_active && rd_plan_q.size() > 0) begin
        rvalid = 1'b1; rdata = rd_plan_q[0].data; rresp = rd_plan_q[0].resp; rlast = rd_plan_q[0].last;
      end else begin
        rvalid = 1'b0; rlast = 1'b0;
      end
      #1;
      if (awvalid) begin
        checks++;
        if (exp_aw_q.size() == 0) begin
          errors++;
          $display("FAIL aw_unexpected: got addr %h, required none", awaddr);
        end else if (awaddr !== exp_aw_q[0].addr || awlen !== exp_aw_q[0].len) begin
          errors++;
          $display("FAIL aw_addr: got %h len %0d, required %h len %0d",
                   awaddr, awlen, exp_aw_q[0].addr, exp_aw_q[0].len);
        end
        if (awready) begin
          if (exp_aw_q.size() > 0) void'(exp_aw_q.pop_front());
          aw_wait = 0;
        end else begin
          aw_wait++;
        end
      end
      if (wvalid && wready) begin
        checks++;
        if (exp_w_q.size() == 0) begin
          errors++;
          $display("FAIL w_unexpected: got beat %h, required none", wdata);
        end else begin
          wb = exp_w_q.pop_front();
          if (wdata !== wb.data || wstrb !== wb.strb || wlast !== wb.last) begin
            errors++;
            $display("FAIL w_beat: got %h strb %h last %b, required %h strb %h last %b",
                     wdata, wstrb, wlast, wb.data, wb.strb, wb.last);
          end
        end
        if (wr_src_q.size() > 0) void'(wr_src_q.pop_front());
        if (wlast) b_pending = 1'b1;
      end
      if (wvalid) w_tog = !w_tog;
      if (bvalid && bready) b_pending = 1'b0;
      if (arvalid && arready) begin
        checks++;
        if (exp_ar_q.size() == 0) begin
          errors++;
          $display("FAIL ar_unexpected: got addr %h, required none", araddr);
        end else if (araddr !== exp_ar_q[0].addr || arlen !== exp_ar_q[0].len) begin
          errors++;
          $display("FAIL ar_addr: got %h len %0d, required %h len %0d",
                   araddr, arlen, exp_ar_q[0].addr, exp_ar_q[0].len);
        end
        if (exp_ar_q.size() > 0) void'(exp_ar_q.pop_front());
        r_active = 1'b1;
      end
      if (rvalid && rready) begin
        rb = rd_plan_q.pop_front();
        if (rb.last) r_active = 1'b0;
      end
    end
  endtask

  task automatic issue_cmd(input logic we, input logic [ADDR_WIDTH-1:0] addr, input logic [LEN_BITS-1:0] len);
    bit ok = 1'b0;
    @(negedge clk_i);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok = cmd_ready;
      @(posedge clk_i);
    end
    @(negedge clk_i);
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cmd_accept: got cmd_ready 0, required 1");
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_seen < target && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (done_seen != target) begin
      errors++;
      $display("FAIL %s_done: got %0d done pulses, required %0d", name, done_seen, target);
    end
    checks++;
    if (exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_rd_q.size() + exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d pending expectations, required 0", name,
               exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_rd_q.size() + exp_done_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i); #2;
    checks++;
    if ({awvalid, wvalid, wlast, bready, arvalid, rready, rd_valid, done, done_resp, cmd_ready} !== 11'b00000000001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000000001",
               {awvalid, wvalid, wlast, bready, arvalid, rready, rd_valid, done, done_resp, cmd_ready});
    end
    rst_ni = 1'b1;
    @(negedge clk_i); #2;
    checks++;
    if ({awaddr, awlen, awsize, awburst, arburst, awid} !== {32'h0, 8'h0, 3'd2, 2'b01, 2'b01, 4'd0}) begin
      errors++;
      $display("FAIL reset_const: got addr %h len %0d size %0d burst %b/%b id %0d, required 0 0 2 01/01 0",
               awaddr, awlen, awsize, awburst, arburst, awid);
    end
  endtask

  task automatic test_single_write();
    int t = done_seen + 1;
    exp_aw_q.push_back('{32'h0000_0100, 8'd0});
    wr_src_q.push_back('{32'hDEAD_BEEF, 4'hF, 1'b1});
    exp_w_q.push_back('{32'hDEAD_BEEF, 4'hF, 1'b1});
    exp_done_q.push_back(2'd0);
    issue_cmd(1'b1, 32'h0000_0100, 8'd0);
    wait_done(t, 100, "single_write");
  endtask

  task automatic test_write_burst();
    int t = done_seen + 1;
    logic [3:0] strbs [4] = '{4'hF, 4'h3, 4'hC, 4'h1};
    aw_delay = 5; w_alt = 1'b1;
    exp_aw_q.push_back('{32'h0000_0400, 8'd3});
    for (int i = 0; i < 4; i++) begin
      wr_src_q.push_back('{32'hA000_0000 + i, strbs[i], 1'b0});
      exp_w_q.push_back('{32'hA000_0000 + i, strbs[i], (i == 3)});
    end
    exp_done_q.push_back(2'd0);
    issue_cmd(1'b1, 32'h0000_0400, 8'd3);
    wait_done(t, 100, "write_burst");
    aw_delay = 0; w_alt = 1'b0;
  endtask

  task automatic test_write_resp();
    int t = done_seen + 1;
    b_resp_cfg = 2'd1;
    exp_aw_q.push_back('{32'h0000_0800, 8'd0});
    wr_src_q.push_back('{32'h1234_5678, 4'h5, 1'b1});
    exp_w_q.push_back('{32'h1234_5678, 4'h5, 1'b1});
    exp_done_q.push_back(2'd1);
    issue_cmd(1'b1, 32'h0000_0800, 8'd0);
    wait_done(t, 100, "write_exokay");
    t = done_seen + 1;
    b_resp_cfg = 2'd0; b_id_cfg = 4'd5;
    exp_aw_q.push_back('{32'h0000_0840, 8'd0});
    wr_src_q.push_back('{32'h8765_4321, 4'hF, 1'b1});
    exp_w_q.push_back('{32'h8765_4321, 4'hF, 1'b1});
    exp_done_q.push_back(2'd2);
    issue_cmd(1'b1, 32'h0000_0840, 8'd0);
    wait_done(t, 100, "write_bid");
    b_id_cfg = 4'd0;
  endtask

  task automatic run_read(input logic [ADDR_WIDTH-1:0] addr, input logic [LEN_BITS-1:0] len,
                          input int beats, input int last_at, input int err_at,
                          input logic [1:0] exp_resp, input string name);
    int t = done_seen + 1;
    exp_ar_q.push_back('{addr, len});
    for (int i = 0; i < beats; i++) begin
      rd_plan_q.push_back('{32'(i), (i == err_at) ? 2'd2 : 2'd0, (i == last_at)});
      exp_rd_q.push_back('{32'(i), 2'd0, (i == beats - 1)});
    end
    exp_done_q.push_back(exp_resp);
    issue_cmd(1'b0, addr, len);
    wait_done(t, 100, name);
  endtask

  task automatic test_reads();
    run_read(32'h0000_2000, 8'd7, 8, 7, -1, 2'd0, "read_burst");
    run_read(32'h0000_2100, 8'd3, 4, 3, 1, 2'd2, "read_slverr");
    run_read(32'h0000_2200, 8'd3, 2, 1, -1, 2'd2, "read_early_last");
  endtask

  task automatic test_timeout();
    int bcnt = 0;
    b_en = 1'b0;
    exp_aw_q.push_back('{32'h0000_0C00, 8'd0});
    wr_src_q.push_back('{32'hCAFE_F00D, 4'hF, 1'b1});
    exp_w_q.push_back('{32'hCAFE_F00D, 4'hF, 1'b1});
    exp_done_q.push_back(2'd3);
    issue_cmd(1'b1, 32'h0000_0C00, 8'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i); #2;
      if (bready) bcnt++;
      if (done) break;
    end
    checks++;
    if (bcnt != 16) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d WRESP cycles, required 16", bcnt);
    end
    @(negedge clk_i); #2;
    checks++;
    if (cmd_ready !== 1'b1 || bready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: got cmd_ready %b bready %b, required 1 0", cmd_ready, bready);
    end
    b_pending = 1'b0; b_en = 1'b1;
    wait_done(done_seen, 10, "timeout");
  endtask

  task automatic test_reset_mid_write();
    w_block = 1'b1;
    exp_aw_q.push_back('{32'h0000_1000, 8'd3});
    for (int i = 0; i < 4; i++) begin
      wr_src_q.push_back('{32'hB000_0000 + i, 4'hF, 1'b0});
      exp_w_q.push_back('{32'hB000_0000 + i, 4'hF, (i == 3)});
    end
    issue_cmd(1'b1, 32'h0000_1000, 8'd3);
    repeat (3) @(negedge clk_i);
    #2;
    checks++;
    if (wvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_wvalid: got %b, required 1", wvalid);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rd_valid, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_valids: got %b, required 0000000",
               {awvalid, wvalid, bready, arvalid, rready, rd_valid, done});
    end
    exp_aw_q.delete(); exp_w_q.delete(); wr_src_q.delete(); exp_done_q.delete();
    w_block = 1'b0; b_pending = 1'b0; r_active = 1'b0; aw_wait = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    run_read(32'h0000_3000, 8'd1, 2, 1, -1, 2'd0, "post_reset_read");
  endtask

  initial begin
    rst_ni = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0; bid = 4'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'd0; rlast = 1'b0; rid = 4'd0;
    fork
      bus_agent();
    join_none
    repeat (3) @(negedge clk_i);
    test_reset();
    test_single_write();
    test_write_burst();
    test_write_resp();
    test_reads();
    test_timeout();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
